divider_datapath: RTL and testbench

//  Restoring-division datapath for the 8-bit Type 2 divider. It sits directly downstream of the

---
 rtl/divider_datapath_if.sv | 29 ++
 rtl/divider_datapath.sv | 81 ++++++++
 tb/tb_divider_datapath.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_datapath_if.sv
// Strobe/status bundle between the divider control block (master) and the
// restoring-division datapath (slave).
interface divider_datapath_if #(
   parameter int N = 8
);
   // Strobes are single-cycle, level-sampled on the rising clock edge.
   // There is no back-pressure. Status flags are combinational from datapath registers.
   logic [N-1:0] Dividend;
   logic [N-1:0] Divisor;
   logic         Load;
   logic         LoadAcc;
   logic         ShiftIn;
   logic         LoadResult;
   logic         nBorrow;
   logic         nZ;
   logic [N-1:0] Quotient;
   logic [N-1:0] Remainder;
   logic         ResultValid;

   modport master (
      output Dividend, Divisor, Load, LoadAcc, ShiftIn, LoadResult,
      input  nBorrow, nZ, Quotient, Remainder, ResultValid
   );

   modport slave (
      input  Dividend, Divisor, Load, LoadAcc, ShiftIn, LoadResult,
      output nBorrow, nZ, Quotient, Remainder, ResultValid
   );
endinterface

// File: rtl/divider_datapath.sv
// Restoring-division datapath: divisor, partial remainder, quotient shifter and result registers.
// Optional scan chain through all registers when DIVIDER_DATAPATH_SCAN_EN is defined.
module divider_datapath #(
   parameter int N = 8
) (
   input  logic              Clock,
   input  logic              nReset,
   divider_datapath_if.slave dp
`ifdef DIVIDER_DATAPATH_SCAN_EN
   ,
   input  logic              Test,
   input  logic              SDI,
   output logic              SDO
`endif
);

   logic [N-1:0] r_b;
   logic [N-1:0] r_r;
   logic [N-1:0] r_q;
   logic [N-1:0] r_quo;
   logic [N-1:0] r_rem;
   logic         r_valid;

   logic [N:0]   w_s;
   logic         w_nborrow;
   logic [N-1:0] w_diff;
   logic [N-1:0] w_r_next;

   // Trial subtraction: the low N bits of S-B are all R ever keeps; the
   // borrow out is equivalent to the unsigned compare S < B.
   assign w_s       = {r_r, r_q[N-1]};
   assign w_nborrow = (w_s >= {1'b0, r_b});
   assign w_diff    = w_s[N-1:0] - r_b;
   assign w_r_next  = w_nborrow ? w_diff : w_s[N-1:0];

   assign dp.nBorrow     = w_nborrow;
   assign dp.nZ          = |r_b;
   assign dp.Quotient    = r_quo;
   assign dp.Remainder   = r_rem;
   assign dp.ResultValid = r_valid;

`ifdef DIVIDER_DATAPATH_SCAN_EN
   logic [5*N:0] w_chain;
   assign w_chain = {r_b, r_r, r_q, r_quo, r_rem, r_valid};
   assign SDO     = r_valid;
`endif

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         r_b     <= '0;
         r_r     <= '0;
         r_q     <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_valid <= 1'b0;
      end
`ifdef DIVIDER_DATAPATH_SCAN_EN
      else if (Test) begin
         {r_b, r_r, r_q, r_quo, r_rem, r_valid} <= {SDI, w_chain[5*N:1]};
      end
`endif
      else if (dp.Load) begin
         r_b     <= dp.Divisor;
         r_q     <= dp.Dividend;
         r_r     <= '0;
         r_valid <= 1'b0;
      end else begin
         // Result capture sees pre-step Q/R when a step happens in the same cycle.
         if (dp.LoadResult) begin
            r_quo   <= r_q;
            r_rem   <= r_r;
            r_valid <= 1'b1;
         end
         if (dp.LoadAcc) begin
            r_r <= w_r_next;
            r_q <= {r_q[N-2:0], dp.ShiftIn};
         end
      end
   end

endmodule

// File: tb/tb_divider_datapath.sv
// Self-checking bench for divider_datapath: arithmetic reference model, per-cycle
// compare process, directed divisions and randomized strobe traffic.
module tb_divider_datapath;
   localparam int N  = 8;
   localparam int CL = 5 * N + 1;

   logic Clock  = 1'b0;
   logic nReset = 1'b0;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 Clock = ~Clock;

   divider_datapath_if #(.N(N)) dp ();

`ifdef DIVIDER_DATAPATH_SCAN_EN
   logic Test = 1'b0;
   logic SDI  = 1'b0;
   logic SDO;
`endif

   divider_datapath #(.N(N)) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .dp     (dp)
`ifdef DIVIDER_DATAPATH_SCAN_EN
      ,
      .Test   (Test),
      .SDI    (SDI),
      .SDO    (SDO)
`endif
   );

   // Reference model: registers held as plain numbers, step done with integer arithmetic.
   logic [N-1:0] m_b, m_r, m_q, m_quo, m_rem;
   logic         m_val;

   function automatic int m_s();
      return int'(m_r) * 2 + int'(m_q[N-1]);
   endfunction

   function automatic logic m_nb();
      return m_s() >= int'(m_b);
   endfunction

   function automatic logic [N-1:0] m_r_next();
      int s;
      s = m_s();
      if (s >= int'(m_b)) return N'(s - int'(m_b));
      return N'(s % (1 << N));
   endfunction

`ifdef DIVIDER_DATAPATH_SCAN_EN
   logic [CL-1:0] m_chain;
   assign m_chain = {m_b, m_r, m_q, m_quo, m_rem, m_val};
`endif

   always @(posedge Clock) begin
      if (!nReset) begin
         m_b <= '0; m_r <= '0; m_q <= '0; m_quo <= '0; m_rem <= '0; m_val <= 1'b0;
      end
`ifdef DIVIDER_DATAPATH_SCAN_EN
      else if (Test) begin
         {m_b, m_r, m_q, m_quo, m_rem, m_val} <= {SDI, m_chain[CL-1:1]};
      end
`endif
      else if (dp.Load) begin
         m_b <= dp.Divisor; m_q <= dp.Dividend; m_r <= '0; m_val <= 1'b0;
      end else begin
         if (dp.LoadResult) begin
            m_quo <= m_q; m_rem <= m_r; m_val <= 1'b1;
         end
         if (dp.LoadAcc) begin
            m_r <= m_r_next();
            m_q <= N'(int'(m_q) * 2 + int'(dp.ShiftIn));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   initial begin
      @(posedge Clock);
      forever begin
         @(negedge Clock);
         chk("cyc_nBorrow", 32'(dp.nBorrow), 32'(m_nb()));
         chk("cyc_nZ", 32'(dp.nZ), 32'(m_b != '0));
         chk("cyc_Quotient", 32'(dp.Quotient), 32'(m_quo));
         chk("cyc_Remainder", 32'(dp.Remainder), 32'(m_rem));
         chk("cyc_ResultValid", 32'(dp.ResultValid), 32'(m_val));
`ifdef DIVIDER_DATAPATH_SCAN_EN
         chk("cyc_SDO", 32'(SDO), 32'(m_val));
`endif
      end
   end

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_load(input int dd, input int dv, input logic acc, input logic res);
      dp.Dividend   = N'(dd);
      dp.Divisor    = N'(dv);
      dp.Load       = 1'b1;
      dp.LoadAcc    = acc;
      dp.LoadResult = res;
      dp.ShiftIn    = 1'($urandom_range(0, 1));
      cyc();
      dp.Load = 1'b0; dp.LoadAcc = 1'b0; dp.LoadResult = 1'b0;
   endtask

   task automatic do_step();
      dp.LoadAcc = 1'b1;
      dp.ShiftIn = m_nb();
      cyc();
      dp.LoadAcc = 1'b0;
   endtask

   task automatic do_result();
      dp.LoadResult = 1'b1;
      cyc();
      dp.LoadResult = 1'b0;
   endtask

   task automatic divide(input int dd, input int dv);
      do_load(dd, dv, 1'b0, 1'b0);
      repeat (N) do_step();
      do_result();
      if (dv != 0) begin
         chk("div_quo", 32'(dp.Quotient), 32'(dd / dv));
         chk("div_rem", 32'(dp.Remainder), 32'(dd % dv));
      end
      chk("div_valid", 32'(dp.ResultValid), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      dp.Dividend = '0; dp.Divisor = '0; dp.Load = 1'b0; dp.LoadAcc = 1'b0;
      dp.ShiftIn = 1'b0; dp.LoadResult = 1'b0;
      nReset = 1'b0;
      repeat (2) cyc();
      chk("rst_quo", 32'(dp.Quotient), 32'd0);
      chk("rst_rem", 32'(dp.Remainder), 32'd0);
      chk("rst_valid", 32'(dp.ResultValid), 32'd0);
      chk("rst_nZ", 32'(dp.nZ), 32'd0);
      chk("rst_nBorrow", 32'(dp.nBorrow), 32'd1);
      nReset = 1'b1;

      divide(100, 7);
      chk("t1_quo", 32'(dp.Quotient), 32'd14);
      chk("t1_rem", 32'(dp.Remainder), 32'd2);
      chk("t1_model_quo", 32'(m_quo), 32'd14);
      chk("t1_model_rem", 32'(m_rem), 32'd2);

      divide(255, 1);
      chk("t2a_quo", 32'(dp.Quotient), 32'd255);
      chk("t2a_rem", 32'(dp.Remainder), 32'd0);
      divide(5, 9);
      chk("t2b_quo", 32'(dp.Quotient), 32'd0);
      chk("t2b_rem", 32'(dp.Remainder), 32'd5);
      divide(255, 255);
      chk("t2c_quo", 32'(dp.Quotient), 32'd1);
      chk("t2c_rem", 32'(dp.Remainder), 32'd0);

      do_load(77, 0, 1'b0, 1'b0);
      chk("t3_nz_zero", 32'(dp.nZ), 32'd0);
      divide(10, 3);
      chk("t3_nz_one", 32'(dp.nZ), 32'd1);
      chk("t3_quo", 32'(dp.Quotient), 32'd3);
      chk("t3_rem", 32'(dp.Remainder), 32'd1);

      do_load(165, 9, 1'b1, 1'b0);
      do_result();
      chk("t4_q_is_dividend", 32'(dp.Quotient), 32'd165);
      chk("t4_r_cleared", 32'(dp.Remainder), 32'd0);
      chk("t4_valid", 32'(dp.ResultValid), 32'd1);
      do_load(1, 1, 1'b0, 1'b1);
      chk("t4_load_wins", 32'(dp.ResultValid), 32'd0);

      do_load(200, 3, 1'b0, 1'b0);
      repeat (4) do_step();
      nReset = 1'b0;
      cyc();
      chk("t5_quo", 32'(dp.Quotient), 32'd0);
      chk("t5_rem", 32'(dp.Remainder), 32'd0);
      chk("t5_valid", 32'(dp.ResultValid), 32'd0);
      chk("t5_nZ", 32'(dp.nZ), 32'd0);
      chk("t5_nBorrow", 32'(dp.nBorrow), 32'd1);
      nReset = 1'b1;
      divide(200, 3);
      chk("t5_quo2", 32'(dp.Quotient), 32'd66);
      chk("t5_rem2", 32'(dp.Remainder), 32'd2);

      for (int i = 0; i < 20; i++) begin
         divide(int'($urandom_range(0, 255)), (i % 5 == 4) ? 0 : int'($urandom_range(1, 255)));
      end

      // Random strobe traffic, including overlaps and steps beyond N.
      for (int i = 0; i < 300; i++) begin
         dp.Dividend   = N'($urandom);
         dp.Divisor    = N'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         dp.Load       = ($urandom_range(0, 9) == 0);
         dp.LoadAcc    = ($urandom_range(0, 1) == 1);
         dp.LoadResult = ($urandom_range(0, 5) == 0);
         dp.ShiftIn    = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 60) == 0) nReset = 1'b0;
         cyc();
         nReset = 1'b1;
      end
      dp.Load = 1'b0; dp.LoadAcc = 1'b0; dp.LoadResult = 1'b0;

`ifdef DIVIDER_DATAPATH_SCAN_EN
      begin
         logic [CL-1:0] pat;
         divide(100, 7);
         pat  = CL'({$urandom, $urandom});
         Test = 1'b1;
         for (int i = 0; i < CL; i++) begin
            SDI           = pat[i];
            dp.Load       = 1'($urandom_range(0, 1));
            dp.LoadAcc    = 1'($urandom_range(0, 1));
            dp.LoadResult = 1'($urandom_range(0, 1));
            cyc();
         end
         for (int i = 0; i < CL; i++) begin
            chk("scan_sdo", 32'(SDO), 32'(pat[i]));
            SDI = 1'b0;
            cyc();
         end
         Test = 1'b0;
         dp.Load = 1'b0; dp.LoadAcc = 1'b0; dp.LoadResult = 1'b0;
         divide(10, 3);
         chk("scan_after_quo", 32'(dp.Quotient), 32'd3);
      end
`endif

      cyc();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
